count_macro_param: RTL and testbench

COUNT_MACRO_PARAM -- requirements
Module: count_macro_param

---
 rtl/count_macro_param.sv | 93 +++++++++
 tb/tb_count_macro_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_macro_param.sv
`default_nettype none
// ============================================================================
// Module   : count_macro_param
// Purpose  : Up/down counter with a programmable prescaler, synchronous load,
//            compare output, terminal-count pulse and sticky overflow flag.
//            Boundaries either wrap (SATURATE=0) or hold (SATURATE=1).
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            en        - count enable, also gates the prescaler
//            up_dn     - 1 = increment, 0 = decrement
//            load      - synchronous load strobe (highest priority)
//            load_val  - value written on load
//            prescale  - step every prescale+1 enabled cycles
//            cmp_val   - compare value for cmp_hit
//            clr_ovf   - clears the sticky overflow flag
//            count     - registered count
//            tc        - one-cycle terminal-count pulse (registered)
//            cmp_hit   - count == cmp_val (combinational from registers)
//            ovf       - sticky boundary-crossing flag (registered)
// Revision : 1.0 - initial release
// ============================================================================
module count_macro_param #(
    parameter int WIDTH    = 4,
    parameter int PRE_W    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cmp_hit,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             at_bound;
    logic             bound_hit;

    // Equality compare only: if prescale drops below pre, pre simply runs on,
    // wraps through zero and matches on the next pass.
    assign tick      = en && (pre == prescale);
    assign at_bound  = up_dn ? (count == MAX_COUNT) : (count == '0);
    // A load on the same edge suppresses the step, so it cannot flag a boundary.
    assign bound_hit = tick && at_bound && !load;
    assign cmp_hit   = (count == cmp_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count <= load_val;
                pre   <= '0;
            end else begin
                if (en) begin
                    pre <= tick ? '0 : pre + PRE_W'(1);
                end
                if (tick) begin
                    if (at_bound) begin
                        tc <= 1'b1;
                        if (!SATURATE) begin
                            count <= up_dn ? '0 : MAX_COUNT;
                        end
                    end else begin
                        count <= up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
                    end
                end
            end
            // Setting on a boundary step wins over a simultaneous clear.
            if (bound_hit) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_macro_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_macro_param
// Purpose  : Directed self-checking bench. Three instances share stimulus:
//            u_a WIDTH=4 wrap, u_b WIDTH=4 saturate, u_c WIDTH=8 wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_macro_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] prescale;
    logic [7:0] cmp_val;
    logic       clr_ovf;

    logic [3:0] a_count;
    logic       a_tc, a_cmp_hit, a_ovf;
    logic [3:0] b_count;
    logic       b_tc, b_cmp_hit, b_ovf;
    logic [7:0] c_count;
    logic       c_tc, c_cmp_hit, c_ovf;

    int vectors;
    int miscompares;

    count_macro_param #(.WIDTH(4), .PRE_W(4), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]), .prescale(prescale), .cmp_val(cmp_val[3:0]),
        .clr_ovf(clr_ovf), .count(a_count), .tc(a_tc), .cmp_hit(a_cmp_hit),
        .ovf(a_ovf)
    );

    count_macro_param #(.WIDTH(4), .PRE_W(4), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]), .prescale(prescale), .cmp_val(cmp_val[3:0]),
        .clr_ovf(clr_ovf), .count(b_count), .tc(b_tc), .cmp_hit(b_cmp_hit),
        .ovf(b_ovf)
    );

    count_macro_param #(.WIDTH(8), .PRE_W(4), .SATURATE(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .prescale(prescale), .cmp_val(cmp_val),
        .clr_ovf(clr_ovf), .count(c_count), .tc(c_tc), .cmp_hit(c_cmp_hit),
        .ovf(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges, released 1 time unit after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        step();
        rst_n = 1'b1;
    endtask

    // Enable pattern for the prescale=2 pause/resume check.
    localparam int EN_LEN = 16;
    logic [EN_LEN-1:0] en_pat;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 8'd0;
        prescale = 4'd0;
        cmp_val  = 8'd0;
        clr_ovf  = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_a_count", a_count, 0);
        check("rst_a_tc", a_tc, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_c_count", c_count, 0);
        check("rst_cmp_hit_zero", a_cmp_hit, 1);
        cmp_val = 8'd3;
        #1;
        check("rst_cmp_hit_three", a_cmp_hit, 0);
        cmp_val = 8'd0;

        // ---------------- free run, prescale=0, up ----------------
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            step();
            check("run_a_count", a_count, i % 16);
            check("run_a_tc", a_tc, (i % 16) == 0);
            check("run_a_ovf", a_ovf, i >= 16);
            check("run_b_count", b_count, (i < 15) ? i : 15);
            check("run_b_tc", b_tc, i >= 16);
            check("run_b_ovf", b_ovf, i >= 16);
            check("run_c_count", c_count, i % 256);
            check("run_c_tc", c_tc, (i % 256) == 0);
            check("run_c_ovf", c_ovf, i >= 256);
        end

        // ---------------- load, clr_ovf vs wrap ----------------
        load     = 1'b1;
        load_val = 8'd15;
        step();
        check("ld15_a_count", a_count, 15);
        check("ld15_a_tc", a_tc, 0);
        check("ld15_b_ovf_kept", b_ovf, 1);
        load    = 1'b0;
        clr_ovf = 1'b1;
        step();
        check("clrwrap_a_count", a_count, 0);
        check("clrwrap_a_tc", a_tc, 1);
        check("clrwrap_a_ovf", a_ovf, 1);
        check("clrwrap_b_tc", b_tc, 1);
        check("clrwrap_b_ovf", b_ovf, 1);
        check("clr_c_ovf", c_ovf, 0);
        step();
        check("clr_a_count", a_count, 1);
        check("clr_a_ovf", a_ovf, 0);
        check("clr_a_tc", a_tc, 0);
        check("clr_b_tc_consec", b_tc, 1);
        clr_ovf = 1'b0;

        // ---------------- async reset at count=11 ----------------
        load     = 1'b1;
        load_val = 8'd11;
        step();
        load = 1'b0;
        check("ld11_a_count", a_count, 11);
        check("ld11_b_ovf", b_ovf, 1);
        rst_n = 1'b0;
        #2;
        check("arst_a_count", a_count, 0);
        check("arst_a_tc", a_tc, 0);
        check("arst_b_ovf", b_ovf, 0);
        check("arst_c_count", c_count, 0);
        step();
        prescale = 4'd2;
        rst_n    = 1'b1;

        // ---------------- prescale=2 with an enable pause ----------------
        en_pat = 16'b1111_1100_0001_1111; // bit 0 applied first
        begin
            int k;
            k = 0;
            for (int i = 0; i < EN_LEN; i++) begin
                en = en_pat[i];
                if (en_pat[i]) k++;
                step();
                check("psc_a_count", a_count, k / 3);
                check("psc_c_count", c_count, k / 3);
            end
        end
        // 11 enabled cycles applied: count=3, pre=2, tick due on next edge.

        // ---------------- load while a tick is due ----------------
        en      = 1'b1;
        cmp_val = 8'd9;
        #1;
        check("pre_ld_cmp_hit", a_cmp_hit, 0);
        load     = 1'b1;
        load_val = 8'd9;
        step();
        load = 1'b0;
        check("ldtick_a_count", a_count, 9);
        check("ldtick_a_tc", a_tc, 0);
        check("ldtick_a_cmp_hit", a_cmp_hit, 1);
        check("ldtick_c_cmp_hit", c_cmp_hit, 1);
        step();
        check("ldtick_p1", a_count, 9);
        step();
        check("ldtick_p2", a_count, 9);
        step();
        check("ldtick_p3", a_count, 10);
        check("ldtick_cmp_off", a_cmp_hit, 0);

        // ---------------- down from zero, direction change ----------------
        prescale = 4'd0;
        do_reset();
        up_dn = 1'b0;
        step();
        check("dn0_a_count", a_count, 15);
        check("dn0_a_tc", a_tc, 1);
        check("dn0_a_ovf", a_ovf, 1);
        check("dn0_b_count", b_count, 0);
        check("dn0_b_tc", b_tc, 1);
        check("dn0_c_count", c_count, 255);
        step();
        check("dn1_a_count", a_count, 14);
        check("dn1_a_tc", a_tc, 0);
        check("dn1_b_count", b_count, 0);
        check("dn1_b_tc", b_tc, 1);
        up_dn = 1'b1;
        step();
        check("dir_a_count", a_count, 15);
        check("dir_b_count", b_count, 1);
        check("dir_b_tc", b_tc, 0);
        check("dir_c_count", c_count, 255);

        // ---------------- prescale reduced below pre ----------------
        prescale = 4'd5;
        do_reset();
        for (int i = 0; i < 4; i++) step();   // pre = 4
        check("red_start", a_count, 0);
        prescale = 4'd1;
        // pre runs 5..15, wraps to 0, reaches 1, then ticks on the 14th edge.
        for (int j = 1; j <= 14; j++) begin
            step();
            check("red_a_count", a_count, (j == 14) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
